// File: rtl/bp_trace_arbiter.sv
// Round-robin arbiter sharing one trace sink between several trace encoders.
// Grants are capped at burst_len_p beats; beats pass through one output register tagged with their source.
module bp_trace_arbiter #(
  parameter int num_src_p     = 4,
  parameter int trace_width_p = 64,
  parameter int burst_len_p   = 4,
  localparam int src_id_width_lp = $clog2(num_src_p),
  localparam int cnt_width_lp    = $clog2(burst_len_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 en_i,
  input  logic [num_src_p*trace_width_p-1:0]   src_data_i,
  input  logic [num_src_p-1:0]                 src_v_i,
  output logic [num_src_p-1:0]                 src_ready_o,
  output logic [trace_width_p-1:0]             trace_data_o,
  output logic [src_id_width_lp-1:0]           trace_src_o,
  output logic                                 trace_v_o,
  input  logic                                 trace_ready_i,
  output logic                                 busy_o
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_e;

  state_e                      r_state, w_state_next;
  logic [src_id_width_lp-1:0]  r_grant, w_grant_next;
  logic [src_id_width_lp-1:0]  r_last_grant, w_last_next;
  logic [cnt_width_lp-1:0]     r_burst_cnt, w_burst_next;
  logic                        r_out_v;
  logic [trace_width_p-1:0]    r_out_data;
  logic [src_id_width_lp-1:0]  r_out_src;

  logic                        w_can_accept;
  logic                        w_accept;
  logic [src_id_width_lp-1:0]  w_pick;
  logic [src_id_width_lp-1:0]  w_idx;
  logic                        w_pick_found;

  assign w_can_accept = !r_out_v || trace_ready_i;

  // Search downward so the closest requester after the last grant is the one left standing.
  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    w_idx        = '0;
    for (int k = num_src_p; k >= 1; k--) begin
      w_idx = src_id_width_lp'((int'(r_last_grant) + k) % num_src_p);
      if (src_v_i[w_idx]) begin
        w_pick       = w_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    src_ready_o = '0;
    if (r_state == GRANT && en_i && w_can_accept) begin
      src_ready_o[r_grant] = 1'b1;
    end
  end

  assign w_accept = src_ready_o[r_grant] & src_v_i[r_grant];

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last_grant;
    w_burst_next = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (en_i && w_pick_found) begin
          w_grant_next = w_pick;
          w_burst_next = '0;
          w_state_next = GRANT;
        end
      end
      GRANT: begin
        if (!en_i) begin
          w_state_next = DRAIN;
        end else if (!src_v_i[r_grant]) begin
          w_state_next = IDLE;
          w_last_next  = r_grant;
        end else if (w_accept) begin
          w_burst_next = r_burst_cnt + 1'b1;
          if (w_burst_next == cnt_width_lp'(burst_len_p)) begin
            w_state_next = IDLE;
            w_last_next  = r_grant;
          end
        end
      end
      DRAIN: begin
        if (!r_out_v) begin
          w_state_next = IDLE;
          w_last_next  = r_grant;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= src_id_width_lp'(num_src_p - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_next;
      r_burst_cnt  <= w_burst_next;
    end
  end

  // Output register only reloads when empty or draining this cycle, so a stalled beat holds still.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else if (w_can_accept) begin
      r_out_v <= w_accept;
      if (w_accept) begin
        r_out_data <= src_data_i[r_grant*trace_width_p +: trace_width_p];
        r_out_src  <= r_grant;
      end
    end
  end

  assign trace_data_o = r_out_data;
  assign trace_src_o  = r_out_src;
  assign trace_v_o    = r_out_v;
  assign busy_o       = (r_state != IDLE) || r_out_v;

endmodule
